addr_gen_sequencer: RTL

Sequences one address generator through a small table of access patterns: per entry, holds the pattern configuration on its config outputs, issues a one-cycle run, waits for the generator's done, then advances.
Sits between the CPU-visible configuration registers and the address generator of a memory unit.
Lets software queue up to ENTRIES patterns with one start command instead of reprogramming between patterns.

---
 rtl/addr_gen_sequencer_if.sv | 26 ++
 rtl/addr_gen_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_sequencer_if.sv
// addr_gen_sequencer_if: run/config/done bundle between the sequencer (master) and one address generator (slave).
interface addr_gen_sequencer_if #(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10,
    parameter int DELAY_W  = 32
);
    logic                ag_run;
    logic [ADDR_W-1:0]   ag_iterations;
    logic [ADDR_W-1:0]   ag_start;
    logic [ADDR_W-1:0]   ag_shift;
    logic [ADDR_W-1:0]   ag_incr;
    logic [PERIOD_W-1:0] ag_period;
    logic [PERIOD_W-1:0] ag_duty;
    logic [DELAY_W-1:0]  ag_delay;
    logic                ag_done;

    modport master (
        output ag_run, ag_iterations, ag_start, ag_shift, ag_incr, ag_period, ag_duty, ag_delay,
        input  ag_done
    );

    modport slave (
        input  ag_run, ag_iterations, ag_start, ag_shift, ag_incr, ag_period, ag_duty, ag_delay,
        output ag_done
    );
endinterface

// File: rtl/addr_gen_sequencer.sv
// addr_gen_sequencer: steps one address generator through a table of up to ENTRIES access patterns per start.
// Optional macro AG_SEQ_LOOP_EN adds a loops input that repeats the whole table sequence loops+1 times.
module addr_gen_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10,
    parameter int DELAY_W  = 32,
    parameter int ENTRIES  = 4,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_iterations,
    input  logic [ADDR_W-1:0]   cfg_start,
    input  logic [ADDR_W-1:0]   cfg_shift,
    input  logic [ADDR_W-1:0]   cfg_incr,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_duty,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic [IDX_W:0]      num_entries,
    input  logic                start,
    input  logic                abort,
`ifdef AG_SEQ_LOOP_EN
    input  logic [7:0]          loops,
`endif
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cur_idx,
    addr_gen_sequencer_if.master ag
);

    typedef struct packed {
        logic [ADDR_W-1:0]   iterations;
        logic [ADDR_W-1:0]   start_addr;
        logic [ADDR_W-1:0]   shift;
        logic [ADDR_W-1:0]   incr;
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] duty;
        logic [DELAY_W-1:0]  delay;
    } entry_t;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, NEXT} state_t;

    localparam logic [IDX_W:0] N_MAX = ENTRIES[IDX_W:0];

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           run_q, run_d;
    logic           first_q, first_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0] n_q, n_d;
    entry_t         cfg_q, cfg_d;
    entry_t         tbl_q [ENTRIES];
    entry_t         tbl_d [ENTRIES];
    entry_t         cfg_in;
    logic [IDX_W:0] n_eff;
    logic [IDX_W:0] idx_nxt;
    logic           last;
    logic           again;
`ifdef AG_SEQ_LOOP_EN
    logic [7:0]     loops_q, loops_d;
    logic [7:0]     lcnt_q, lcnt_d;
    assign again = lcnt_q < loops_q;
`else
    assign again = 1'b0;
`endif

    assign cfg_in  = {cfg_iterations, cfg_start, cfg_shift, cfg_incr, cfg_period, cfg_duty, cfg_delay};
    assign n_eff   = (num_entries > N_MAX) ? N_MAX : num_entries;
    assign idx_nxt = {1'b0, idx_q} + {{IDX_W{1'b0}}, 1'b1};
    assign last    = idx_nxt == n_q;

    assign busy             = busy_q;
    assign done             = done_q;
    assign cur_idx          = idx_q;
    assign ag.ag_run        = run_q;
    assign ag.ag_iterations = cfg_q.iterations;
    assign ag.ag_start      = cfg_q.start_addr;
    assign ag.ag_shift      = cfg_q.shift;
    assign ag.ag_incr       = cfg_q.incr;
    assign ag.ag_period     = cfg_q.period;
    assign ag.ag_duty       = cfg_q.duty;
    assign ag.ag_delay      = cfg_q.delay;

    // Next-state logic: table writes, sequencing FSM, abort override last so it wins everywhere outside IDLE
    always_comb begin
        tbl_d   = tbl_q;
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        run_d   = 1'b0;
        first_d = 1'b0;
        idx_d   = idx_q;
        n_d     = n_q;
        cfg_d   = cfg_q;
`ifdef AG_SEQ_LOOP_EN
        loops_d = loops_q;
        lcnt_d  = lcnt_q;
`endif
        if (cfg_we)
            tbl_d[cfg_idx] = cfg_in;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_d = n_eff;
                    if (n_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        busy_d  = 1'b1;
                        idx_d   = '0;
`ifdef AG_SEQ_LOOP_EN
                        loops_d = loops;
                        lcnt_d  = '0;
`endif
                    end
                end
            end
            LOAD: begin
                cfg_d   = tbl_q[idx_q];
                run_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                first_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // first WAIT cycle may still see the previous run's done level
                if (!first_q && ag.ag_done)
                    state_d = NEXT;
            end
            NEXT: begin
                if (last && !again) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef AG_SEQ_LOOP_EN
                    lcnt_d  = '0;
`endif
                end else if (last) begin
                    idx_d   = '0;
                    state_d = LOAD;
`ifdef AG_SEQ_LOOP_EN
                    lcnt_d  = lcnt_q + 8'd1;
`endif
                end else begin
                    idx_d   = idx_nxt[IDX_W-1:0];
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            run_d   = 1'b0;
            cfg_d   = cfg_q;
`ifdef AG_SEQ_LOOP_EN
            lcnt_d  = '0;
`endif
        end
    end

    // State, registered outputs and pattern table
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            first_q <= 1'b0;
            idx_q   <= '0;
            n_q     <= '0;
            cfg_q   <= '0;
            tbl_q   <= '{default: '0};
`ifdef AG_SEQ_LOOP_EN
            loops_q <= '0;
            lcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            run_q   <= run_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cfg_q   <= cfg_d;
            tbl_q   <= tbl_d;
`ifdef AG_SEQ_LOOP_EN
            loops_q <= loops_d;
            lcnt_q  <= lcnt_d;
`endif
        end
    end

endmodule
